rr_resource_arbiter: RTL and testbench

- Round-robin arbiter that shares one execution resource (e.g. a single divider or CSR port) between WIDTH requesters.
- Picks the next requester with the existing priority_finder, offers a registered one-hot grant, and handshakes acceptance with the resource.
- Can hold ownership until the owner releases it, with a watchdog timeout.

---
 rtl/rr_resource_arbiter_pkg.sv | 10 +
 rtl/rr_resource_arbiter_priority_finder.sv | 36 +++
 rtl/rr_resource_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_resource_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_resource_arbiter_pkg.sv
// Shared types for the round-robin resource arbiter.
package rr_resource_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_resource_arbiter_priority_finder.sv
// Fixed-priority finder: reports the lowest (FIRST_PRIORITY=1) or highest
// (FIRST_PRIORITY=0) set bit of in_vec as an index and a one-hot vector.
module priority_finder #(
  parameter int WIDTH          = 8,
  parameter int FIRST_PRIORITY = 1,
  parameter int INDEX_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]   in_vec,
  output logic               found,
  output logic [INDEX_W-1:0] index,
  output logic [WIDTH-1:0]   onehot
);

  always_comb begin
    found = 1'b0;
    index = '0;
    if (FIRST_PRIORITY != 0) begin
      // Scan downward so the last hit (lowest index) wins.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_vec[i]) begin
          found = 1'b1;
          index = INDEX_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_vec[i]) begin
          found = 1'b1;
          index = INDEX_W'(i);
        end
      end
    end
    onehot = found ? (WIDTH'(1) << index) : '0;
  end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter sharing one resource between WIDTH requesters, with an
// optional ownership lock released by the owner or by a watchdog.
module rr_resource_arbiter
  import rr_resource_arbiter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int INDEX_W = $clog2(WIDTH),
  parameter int LOCK    = 1,
  parameter int TIMEOUT = 256,
  parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   req,
  input  logic               res_ready,
  input  logic               res_release,
  output logic [WIDTH-1:0]   grant,
  output logic [INDEX_W-1:0] grant_index,
  output logic               grant_valid,
  output logic               busy,
  output logic               timeout_err
);

  // With the watchdog disabled TMR_W collapses to 0; keep a 1-bit stub.
  localparam int TW = (TMR_W > 0) ? TMR_W : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  arb_state_t         state_q, state_d;
  logic [WIDTH-1:0]   grant_q, grant_d;
  logic [INDEX_W-1:0] grant_index_q, grant_index_d;
  logic [INDEX_W-1:0] last_ptr_q, last_ptr_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               timeout_err_q, timeout_err_d;

  logic [WIDTH-1:0]   mask;
  logic               msk_found, all_found;
  logic [INDEX_W-1:0] msk_idx, all_idx, win_idx;
  logic [WIDTH-1:0]   msk_oh, all_oh, win_oh;

  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (i > int'(last_ptr_q));
    end
  end

  priority_finder #(.WIDTH(WIDTH), .FIRST_PRIORITY(1), .INDEX_W(INDEX_W)) u_pf_masked (
    .in_vec (req & mask),
    .found  (msk_found),
    .index  (msk_idx),
    .onehot (msk_oh)
  );

  priority_finder #(.WIDTH(WIDTH), .FIRST_PRIORITY(1), .INDEX_W(INDEX_W)) u_pf_all (
    .in_vec (req),
    .found  (all_found),
    .index  (all_idx),
    .onehot (all_oh)
  );

  // Requesters above the last winner go first; otherwise wrap to the bottom.
  assign win_idx = msk_found ? msk_idx : all_idx;
  assign win_oh  = msk_found ? msk_oh  : all_oh;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_index_d = grant_index_q;
    last_ptr_d    = last_ptr_q;
    timer_d       = timer_q;
    timeout_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (all_found) begin
          state_d       = OFFER;
          grant_d       = win_oh;
          grant_index_d = win_idx;
        end
      end
      OFFER: begin
        // A withdrawn request loses the offer even if the resource is ready.
        if (!req[grant_index_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (res_ready) begin
          grant_d    = '0;
          last_ptr_d = grant_index_q;
          if (LOCK != 0) begin
            state_d = BUSY;
            timer_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BUSY: begin
        if (res_release) begin
          state_d = IDLE;
        end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_index_q <= '0;
      last_ptr_q    <= INDEX_W'(WIDTH - 1);
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_index_q <= grant_index_d;
      last_ptr_q    <= last_ptr_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign grant_index = grant_index_q;
  assign grant_valid = (state_q == OFFER);
  assign busy        = (state_q == BUSY);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Randomized and directed bench for rr_resource_arbiter: a LOCK=0 instance and
// a LOCK=1/TIMEOUT=16 instance, both checked every cycle against a queue-free
// rotating-search reference model.
module tb_rr_resource_arbiter;
  localparam int W  = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0]  req_a  [2];
  logic          rdy_a  [2];
  logic          rel_a  [2];
  logic [W-1:0]  gnt_a  [2];
  logic [IW-1:0] gidx_a [2];
  logic          gvld_a [2];
  logic          busy_a [2];
  logic          tout_a [2];

  rr_resource_arbiter #(.WIDTH(W), .LOCK(0), .TIMEOUT(256)) u_dut0 (
    .clk(clk), .rst(rst), .req(req_a[0]), .res_ready(rdy_a[0]), .res_release(rel_a[0]),
    .grant(gnt_a[0]), .grant_index(gidx_a[0]), .grant_valid(gvld_a[0]),
    .busy(busy_a[0]), .timeout_err(tout_a[0])
  );

  rr_resource_arbiter #(.WIDTH(W), .LOCK(1), .TIMEOUT(16)) u_dut1 (
    .clk(clk), .rst(rst), .req(req_a[1]), .res_ready(rdy_a[1]), .res_release(rel_a[1]),
    .grant(gnt_a[1]), .grant_index(gidx_a[1]), .grant_valid(gvld_a[1]),
    .busy(busy_a[1]), .timeout_err(tout_a[1])
  );

  // Reference model: who is being offered, who owns, who won last.
  int m_off [2];
  int m_own [2];
  int m_last[2];
  int m_tmr [2];
  int m_idx [2];
  int m_terr[2];
  int m_lock[2] = '{0, 1};
  int m_to  [2] = '{256, 16};

  int n_cmp = 0;
  int n_err = 0;
  int tcount = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_off[k] = -1; m_own[k] = -1; m_last[k] = W - 1;
      m_tmr[k] = 0;  m_idx[k] = 0;  m_terr[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int off, own;
    off = m_off[k];
    own = m_own[k];
    m_terr[k] = 0;
    if (off >= 0) begin
      if (!req_a[k][off]) begin
        m_off[k] = -1;
      end else if (rdy_a[k]) begin
        m_last[k] = off;
        m_off[k]  = -1;
        if (m_lock[k] != 0) begin
          m_own[k] = off;
          m_tmr[k] = 0;
        end
      end
    end else if (own >= 0) begin
      if (rel_a[k]) begin
        m_own[k] = -1;
      end else if (m_to[k] != 0 && m_tmr[k] == m_to[k] - 1) begin
        m_own[k]  = -1;
        m_terr[k] = 1;
      end else begin
        m_tmr[k]++;
      end
    end else if (req_a[k] != '0) begin
      for (int j = 1; j <= W; j++) begin
        int i;
        i = (m_last[k] + j) % W;
        if (req_a[k][i]) begin
          m_off[k] = i;
          m_idx[k] = i;
          break;
        end
      end
    end
  endtask

  task automatic check_inst(input int k);
    logic [31:0] eg;
    eg = (m_off[k] >= 0) ? (32'd1 << m_off[k]) : 32'd0;
    chk($sformatf("u%0d.grant", k), 32'(gnt_a[k]), eg);
    chk($sformatf("u%0d.grant_index", k), 32'(gidx_a[k]), 32'(m_idx[k]));
    chk($sformatf("u%0d.grant_valid", k), 32'(gvld_a[k]), 32'(m_off[k] >= 0));
    chk($sformatf("u%0d.busy", k), 32'(busy_a[k]), 32'(m_own[k] >= 0));
    chk($sformatf("u%0d.timeout_err", k), 32'(tout_a[k]), 32'(m_terr[k]));
    chk($sformatf("u%0d.excl", k), 32'(gvld_a[k] & busy_a[k]), 32'd0);
  endtask

  task automatic cyc(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      check_inst(0);
      check_inst(1);
      tcount += int'(tout_a[1]);
    end
  endtask

  // Assert reset between edges, check the clear happens before any clock.
  task automatic areset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_inst(0);
    check_inst(1);
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_a[k] = '0; rdy_a[k] = 1'b0; rel_a[k] = 1'b0;
    end
    @(negedge clk);
    model_reset();
    check_inst(0);
    check_inst(1);
    rst = 1'b1;

    // Two requesters alternate, then full rotation.
    req_a[0] = 8'h81; rdy_a[0] = 1'b1; cyc(8);
    req_a[0] = 8'hFF; cyc(18);
    req_a[0] = 8'h00; cyc(2);
    areset();

    // Withdraw while offered leaves last_ptr alone.
    req_a[0] = 8'h04; rdy_a[0] = 1'b0; cyc(3);
    req_a[0] = 8'h00; cyc(1);
    chk("withdraw_gv", 32'(gvld_a[0]), 32'd0);
    req_a[0] = 8'h06; cyc(2);
    chk("withdraw_idx", 32'(gidx_a[0]), 32'd1);
    req_a[0] = 8'h00; rdy_a[0] = 1'b1; cyc(2);

    // Locked ownership and release bubble.
    req_a[1] = 8'h08; rdy_a[1] = 1'b1; cyc(2);
    req_a[1] = 8'hFF; rdy_a[1] = 1'b0; cyc(5);
    chk("lock_busy", 32'(busy_a[1]), 32'd1);
    rel_a[1] = 1'b1; cyc(1);
    rel_a[1] = 1'b0; cyc(1);
    chk("lock_next", 32'(gidx_a[1]), 32'd4);

    // Watchdog expiry.
    rdy_a[1] = 1'b1; cyc(1);
    rdy_a[1] = 1'b0; tcount = 0; cyc(20);
    chk("terr_once", 32'(tcount), 32'd1);
    chk("terr_next", 32'(gidx_a[1]), 32'd5);

    // Async reset with one instance offering and one busy.
    req_a[0] = 8'h04; rdy_a[0] = 1'b0; rdy_a[1] = 1'b1; cyc(1);
    rdy_a[1] = 1'b0; cyc(1);
    chk("pre_rst_gv0", 32'(gvld_a[0]), 32'd1);
    chk("pre_rst_busy1", 32'(busy_a[1]), 32'd1);
    areset();
    req_a[0] = 8'hFF; req_a[1] = 8'hFF; cyc(1);
    chk("post_rst_idx0", 32'(gidx_a[0]), 32'd0);
    chk("post_rst_idx1", 32'(gidx_a[1]), 32'd0);

    // Random traffic, with requests mostly held and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 3) == 0)
          req_a[k] = W'($urandom_range(0, 255) & $urandom_range(0, 255));
        rdy_a[k] = ($urandom_range(0, 2) != 0);
        rel_a[k] = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 499) == 0) areset();
      else cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
